// File: rtl/square_seq.sv
// square_seq: iterative unsigned squarer, din*din by radix-2 shift-add, one bit per clock,
// with valid/ready handshakes on both sides and one operation in flight.
module square_seq #(
   parameter int N = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [N-1:0]   din,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*N-1:0] dout,
   output logic           busy
);
   localparam int CW = $clog2(N);
   localparam logic [CW-1:0] LAST = CW'(N - 1);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   state_t           state, next_state;
   logic [N-1:0]     op_a;
   logic [2*N-1:0]   op_b, acc, acc_sum;
   logic [CW-1:0]    cnt;
   assign in_ready  = state == IDLE;
   assign busy      = state == BUSY;
   assign out_valid = state == DONE;
   assign acc_sum   = acc + (op_a[0] ? op_b : '0);
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end
   always_comb begin
      next_state = state;
      next_state = (state == IDLE && in_valid)  ? BUSY :
                   (state == BUSY && cnt == LAST) ? DONE :
                   (state == DONE && out_ready) ? IDLE : state;
   end
   // dout is loaded with this step's sum on the final BUSY edge
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         op_a <= '0;
         op_b <= '0;
         acc  <= '0;
         cnt  <= '0;
         dout <= '0;
      end else if (state == IDLE && in_valid) begin
         op_a <= din;
         op_b <= {{N{1'b0}}, din};
         acc  <= '0;
         cnt  <= '0;
      end else if (state == BUSY) begin
         acc  <= acc_sum;
         op_a <= op_a >> 1;
         op_b <= op_b << 1;
         cnt  <= cnt + 1'b1;
         if (cnt == LAST) dout <= acc_sum;
      end
   end
endmodule
